// File: rtl/elevator_scan_ctrl.sv
// Single-cabin SCAN elevator controller: latches cabin and hall calls, then
// sweeps in one direction serving stops until nothing lies ahead.
module elevator_scan_ctrl #(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = $clog2(FLOORS),
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [FLOORS-1:0]  call_in,
  input  logic [FLOORS-1:0]  call_up,
  input  logic [FLOORS-1:0]  call_down,
  input  logic               door_hold,
  output logic [FLOOR_W-1:0] cur_floor_out,
  output logic               direction_out,
  output logic               open,
  output logic               moving,
  output logic [FLOORS-1:0]  pending
);

  localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [FLOORS-1:0] ONE   = FLOORS'(1);
  localparam logic [FLOORS-1:0] UP_OK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_OK = {{(FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t             state;
  logic [FLOORS-1:0]  req_in, req_up, req_down;
  logic [MCW-1:0]     move_cnt;
  logic [DCW-1:0]     door_cnt;

  logic [FLOORS-1:0]  set_in, set_up, set_dn;
  logic [FLOORS-1:0]  eff_in, eff_up, eff_dn, eff_all;
  logic [FLOORS-1:0]  above_cur, below_cur, above_nx, below_nx;
  logic [FLOORS-1:0]  oh_cur, oh_nx;
  logic [FLOOR_W-1:0] nx_floor;
  logic               here_in, here_up, here_dn, here_dir, here_opp, here_any;
  logic               ahead_cur, behind_cur, new_match;
  logic               nx_in, nx_up, nx_dn, nx_dir, nx_opp, ahead_nx, stop_nx;
  logic               flip_cur, flip_nx, move_done, door_done;
  logic [FLOORS-1:0]  clr_in, clr_up, clr_dn;
  logic [FLOORS-1:0]  req_in_next, req_up_next, req_down_next;

  // Hall calls that point off the building are not latchable.
  assign set_in  = call_in;
  assign set_up  = call_up & UP_OK;
  assign set_dn  = call_down & DN_OK;
  assign eff_in  = req_in | set_in;
  assign eff_up  = req_up | set_up;
  assign eff_dn  = req_down | set_dn;
  assign eff_all = eff_in | eff_up | eff_dn;

  assign nx_floor = direction_out
                  ? ((cur_floor_out == FLOOR_W'(FLOORS-1)) ? cur_floor_out : cur_floor_out + FLOOR_W'(1))
                  : ((cur_floor_out == '0) ? cur_floor_out : cur_floor_out - FLOOR_W'(1));
  assign oh_cur = ONE << cur_floor_out;
  assign oh_nx  = ONE << nx_floor;

  genvar gi;
  generate
    for (gi = 0; gi < FLOORS; gi++) begin : g_mask
      localparam logic [FLOOR_W:0] IDX = (FLOOR_W+1)'(gi);
      assign above_cur[gi] = IDX > {1'b0, cur_floor_out};
      assign below_cur[gi] = IDX < {1'b0, cur_floor_out};
      assign above_nx[gi]  = IDX > {1'b0, nx_floor};
      assign below_nx[gi]  = IDX < {1'b0, nx_floor};
    end
  endgenerate

  assign here_in    = |(eff_in & oh_cur);
  assign here_up    = |(eff_up & oh_cur);
  assign here_dn    = |(eff_dn & oh_cur);
  assign here_dir   = direction_out ? here_up : here_dn;
  assign here_opp   = direction_out ? here_dn : here_up;
  assign here_any   = here_in | here_dir | here_opp;
  assign ahead_cur  = |(eff_all & (direction_out ? above_cur : below_cur));
  assign behind_cur = |(eff_all & (direction_out ? below_cur : above_cur));
  assign flip_cur   = here_opp & ~ahead_cur;

  // Fresh presses at the open door that it would serve anyway restart the timer.
  assign new_match = |(set_in & oh_cur)
                   | (direction_out ? |(set_up & oh_cur) : |(set_dn & oh_cur))
                   | (~ahead_cur & (direction_out ? |(set_dn & oh_cur) : |(set_up & oh_cur)));

  assign nx_in    = |(eff_in & oh_nx);
  assign nx_up    = |(eff_up & oh_nx);
  assign nx_dn    = |(eff_dn & oh_nx);
  assign nx_dir   = direction_out ? nx_up : nx_dn;
  assign nx_opp   = direction_out ? nx_dn : nx_up;
  assign ahead_nx = |(eff_all & (direction_out ? above_nx : below_nx));
  assign stop_nx  = nx_in | nx_dir | (nx_opp & ~ahead_nx);
  assign flip_nx  = nx_opp & ~ahead_nx;

  assign move_done = (move_cnt == MCW'(MOVE_CYCLES-1));
  assign door_done = (door_cnt == DCW'(DOOR_CYCLES-1));

  always_comb begin
    clr_in = '0;
    clr_up = '0;
    clr_dn = '0;
    case (state)
      IDLE: if (here_any) begin
        clr_in = oh_cur;
        clr_up = (direction_out | ~ahead_cur) ? oh_cur : '0;
        clr_dn = (~direction_out | ~ahead_cur) ? oh_cur : '0;
      end
      MOVE: if (move_done && stop_nx) begin
        clr_in = oh_nx;
        clr_up = (direction_out | ~ahead_nx) ? oh_nx : '0;
        clr_dn = (~direction_out | ~ahead_nx) ? oh_nx : '0;
      end
      DOOR: begin
        clr_in = oh_cur;
        clr_up = (direction_out | ~ahead_cur) ? oh_cur : '0;
        clr_dn = (~direction_out | ~ahead_cur) ? oh_cur : '0;
      end
      default: ;
    endcase
    req_in_next   = eff_in & ~clr_in;
    req_up_next   = eff_up & ~clr_up;
    req_down_next = eff_dn & ~clr_dn;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cur_floor_out <= '0;
      direction_out <= 1'b1;
      open          <= 1'b0;
      moving        <= 1'b0;
      req_in        <= '0;
      req_up        <= '0;
      req_down      <= '0;
      pending       <= '0;
      move_cnt      <= '0;
      door_cnt      <= '0;
    end else begin
      req_in   <= req_in_next;
      req_up   <= req_up_next;
      req_down <= req_down_next;
      pending  <= req_in_next | req_up_next | req_down_next;
      case (state)
        IDLE: begin
          if (here_any) begin
            state    <= DOOR;
            open     <= 1'b1;
            door_cnt <= '0;
            if (flip_cur) direction_out <= ~direction_out;
          end else if (ahead_cur || behind_cur) begin
            state    <= MOVE;
            moving   <= 1'b1;
            move_cnt <= '0;
            if (!ahead_cur) direction_out <= ~direction_out;
          end
        end
        MOVE: begin
          if (move_done) begin
            move_cnt      <= '0;
            cur_floor_out <= nx_floor;
            if (stop_nx) begin
              state    <= DOOR;
              moving   <= 1'b0;
              open     <= 1'b1;
              door_cnt <= '0;
              if (flip_nx) direction_out <= ~direction_out;
            end else if (!ahead_nx) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else begin
            move_cnt <= move_cnt + MCW'(1);
          end
        end
        DOOR: begin
          if (flip_cur) direction_out <= ~direction_out;
          if (door_hold || new_match) begin
            door_cnt <= '0;
          end else if (door_done) begin
            open     <= 1'b0;
            door_cnt <= '0;
            if (ahead_cur || behind_cur) begin
              state    <= MOVE;
              moving   <= 1'b1;
              move_cnt <= '0;
              if (!ahead_cur) direction_out <= ~direction_out;
            end else begin
              state <= IDLE;
            end
          end else begin
            door_cnt <= door_cnt + DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): FLOORS, 8, number of floors (2..32).
REQ-002 FLOOR_W, 3, floor index width, SHALL equal ceil(log2(FLOORS)).
REQ-003 MOVE_CYCLES, 4, clocks to travel one floor (>=1).
REQ-004 DOOR_CYCLES, 3, clocks door stays open (>=1).
REQ-005 Ports (name, direction, width, meaning): clock, in, 1, sole clock, rising edge.
REQ-006 reset_n, in, 1, reset; asynchronous, active-low.
REQ-007 call_in, in, FLOORS, cabin floor buttons, level-sampled each edge.
REQ-008 call_up / call_down, in, FLOORS each, hall buttons.
REQ-009 door_hold, in, 1, holds door open while high in DOOR.
REQ-010 cur_floor_out, out, FLOOR_W, current floor.
REQ-011 direction_out, out, 1, 1 = up, 0 = down.
REQ-012 open, out, 1, door open; moving, out, 1, cabin travelling.
REQ-013 pending, out, FLOORS, OR of all latched requests per floor.

Function
REQ-014 Request registers req_in/req_up/req_down SHALL set on any edge where the matching input bit is 1 and hold until served.
REQ-015 call_up[FLOORS-1] and call_down[0] SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, MOVE, DOOR; all outputs registered.
REQ-017 "Ahead" = any request strictly beyond cur_floor in direction_out; "behind" = strictly the other side.
REQ-018 IDLE: request at cur_floor -> DOOR next edge; else ahead -> MOVE; else behind -> toggle direction, MOVE; else stay IDLE.
REQ-019 MOVE: moving=1; counter counts MOVE_CYCLES edges, then cur_floor_out steps +/-1 on that edge.
REQ-020 On arrival at floor f, stop (-> DOOR) if req_in[f], or dir-matching hall call at f, or opposite hall call at f with nothing ahead; else continue MOVE.
REQ-021 Arrival with nothing at f and nothing ahead SHALL go to IDLE.
REQ-022 cur_floor_out SHALL never pass 0 or FLOORS-1; direction flips at the end floors if requests lie behind.
REQ-023 Entering DOOR SHALL clear req_in[f] and the hall call in direction_out at f; the opposite hall call is cleared only if nothing is ahead (direction then flips on entry).
REQ-024 DOOR: open=1 for DOOR_CYCLES edges; door_hold=1 or a new call matching REQ-023 at f SHALL reload the timer and not latch.
REQ-025 DOOR expiry: ahead -> MOVE; else behind -> flip direction, MOVE; else IDLE.
REQ-026 open and moving SHALL never both be 1.
REQ-027 A set and a clear of the same request on one edge SHALL leave it cleared only in the REQ-024 case; otherwise set wins.
REQ-028 Latency: call at idle cabin floor -> open=1 after exactly 1 edge; call k floors away -> open after 1 + k*MOVE_CYCLES edges.

Reset
REQ-029 reset_n low SHALL immediately force: state IDLE, cur_floor_out 0, direction_out 1, open 0, moving 0, all requests and counters 0.
REQ-030 Reset asserted mid-MOVE or mid-DOOR SHALL abandon the operation; no request survives reset.

Verification (FLOORS=8, MOVE_CYCLES=4, DOOR_CYCLES=3)
REQ-031 Reset, call_in[0] one cycle -> open=1 one edge later for 3 edges, then IDLE, pending=0.
REQ-032 Idle at 0, call_in[5] -> moving for 20 edges, floor 5, open 3 edges, pending[5] cleared.
REQ-033 At floor 2 going up with call_in[6], raise call_down[4] and call_up[4] -> stops at 4 (up call cleared), continues to 6, returns to 4 for call_down.
REQ-034 Door open at 3, hold door_hold 5 cycles -> open stays 1 until 3 edges after release.
REQ-035 Idle at 7, call_up[7] -> ignored; call_down[0] -> ignored; call_up[0] -> direction_out 0, travel to 0.
REQ-036 reset_n low mid-MOVE between floors 3 and 4 -> outputs reset asynchronously, floor 0, pending 0.
